// File: rtl/tcp_pkg.sv
// Shared TCP RX types: flow tuple layout, flow-table response and default table size.
package tcp_pkg;

    localparam int MAX_FLOW_CNT = 64;
    localparam int FLOWID_MAX_W = 16;

    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
    } flow_lookup_entry;

    localparam int FLOW_TAG_W = $bits(flow_lookup_entry);

    // flowid is sized for the largest supported table; users take the low bits.
    typedef struct packed {
        logic                    hit;
        logic                    new_flow;
        logic                    full;
        logic [FLOWID_MAX_W-1:0] flowid;
    } flow_table_resp;

    typedef enum logic {
        FT_INIT,
        FT_READY
    } ft_state_e;

endpackage

// File: rtl/flowid_free_list.sv
// FIFO of unused flow IDs; oldest-freed ID is handed out first.
module flowid_free_list #(
    parameter int DEPTH = 64,
    parameter int ID_W  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [ID_W-1:0] push_id,
    input  logic            pop,
    output logic [ID_W-1:0] pop_id,
    output logic            empty,
    output logic [ID_W:0]   count
);

    logic [ID_W-1:0] mem [DEPTH];
    logic [ID_W-1:0] head;
    logic [ID_W-1:0] tail;
    logic            full;
    logic            pop_ok;
    logic            push_ok;

    assign empty   = (count == '0);
    assign full    = (count == (ID_W+1)'(DEPTH));
    assign pop_ok  = pop & ~empty;
    // A push into a full list is only legal when a pop frees a slot the same cycle.
    assign push_ok = push & (~full | pop_ok);
    assign pop_id  = mem[head];

    always_ff @(posedge clk) begin
        if (push_ok) mem[tail] <= push_id;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_ok) tail <= tail + 1'b1;
            if (pop_ok)  head <= head + 1'b1;
            count <= count + (ID_W+1)'(push_ok) - (ID_W+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/tcp_flow_table.sv
// 4-tuple to flow-ID CAM with allocate-on-miss, flow teardown and occupancy count.
module tcp_flow_table
    import tcp_pkg::*;
#(
    parameter int NUM_FLOWS = MAX_FLOW_CNT,
    parameter int TAG_W     = FLOW_TAG_W,
    parameter int FLOWID_W  = $clog2(NUM_FLOWS)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                init_done,
    input  logic                lookup_req_val,
    input  logic [TAG_W-1:0]    lookup_req_tag,
    input  logic                lookup_req_alloc,
    output logic                lookup_req_rdy,
    output logic                lookup_resp_val,
    output logic                lookup_resp_hit,
    output logic                lookup_resp_new,
    output logic                lookup_resp_full,
    output logic [FLOWID_W-1:0] lookup_resp_flowid,
    input  logic                lookup_resp_rdy,
    input  logic                free_req_val,
    input  logic [FLOWID_W-1:0] free_req_flowid,
    output logic                free_req_rdy,
    output logic                free_err,
    output logic [FLOWID_W:0]   active_flows
);

    ft_state_e           state;
    ft_state_e           state_nxt;
    logic [FLOWID_W-1:0] init_id;
    logic                init_push;
    logic                ready;

    logic [TAG_W-1:0]     tags [NUM_FLOWS];
    logic [NUM_FLOWS-1:0] valid;
    logic [NUM_FLOWS-1:0] match;
    logic                 hit;
    logic [FLOWID_W-1:0]  hit_id;

    logic                req_acc;
    logic                alloc_do;
    logic                free_acc;
    logic                free_vld;
    logic                free_ok;

    logic                fl_push;
    logic [FLOWID_W-1:0] fl_push_id;
    logic [FLOWID_W-1:0] fl_pop_id;
    logic                fl_empty;
    logic [FLOWID_W:0]   fl_count;

    flow_table_resp      resp_q;

    always_ff @(posedge clk) begin
        if (rst) state <= FT_INIT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        init_push = 1'b0;
        case (state)
            FT_INIT: begin
                init_push = 1'b1;
                if (init_id == FLOWID_W'(NUM_FLOWS-1)) state_nxt = FT_READY;
            end
            FT_READY: state_nxt = FT_READY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)            init_id <= '0;
        else if (init_push) init_id <= init_id + 1'b1;
    end

    assign ready          = (state == FT_READY);
    assign init_done      = ready;
    assign free_req_rdy   = ready;
    assign lookup_req_rdy = ready & (~lookup_resp_val | lookup_resp_rdy);

    // Valid entries hold distinct tags, so at most one match bit is set and OR-ing indices encodes it.
    always_comb begin
        match  = '0;
        hit_id = '0;
        for (int i = 0; i < NUM_FLOWS; i++) begin
            match[i] = valid[i] && (tags[i] == lookup_req_tag);
            if (match[i]) hit_id = hit_id | FLOWID_W'(i);
        end
    end

    assign hit      = |match;
    assign req_acc  = lookup_req_val & lookup_req_rdy;
    assign alloc_do = req_acc & ~hit & lookup_req_alloc & ~fl_empty;
    assign free_acc = free_req_val & ready;
    assign free_vld = valid[free_req_flowid];
    assign free_ok  = free_acc & free_vld;

    // INIT and teardown never overlap: frees are only taken once READY.
    assign fl_push    = init_push | free_ok;
    assign fl_push_id = init_push ? init_id : free_req_flowid;

    flowid_free_list #(
        .DEPTH (NUM_FLOWS),
        .ID_W  (FLOWID_W)
    ) u_free_list (
        .clk     (clk),
        .rst     (rst),
        .push    (fl_push),
        .push_id (fl_push_id),
        .pop     (alloc_do),
        .pop_id  (fl_pop_id),
        .empty   (fl_empty),
        .count   (fl_count)
    );

    // A freshly popped ID is never valid, so it cannot collide with a same-cycle free.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else begin
            if (free_ok)  valid[free_req_flowid] <= 1'b0;
            if (alloc_do) valid[fl_pop_id]       <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_do) tags[fl_pop_id] <= lookup_req_tag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lookup_resp_val <= 1'b0;
            resp_q          <= '0;
        end else if (req_acc) begin
            lookup_resp_val <= 1'b1;
            resp_q.hit      <= hit;
            resp_q.new_flow <= alloc_do;
            resp_q.full     <= ~hit & lookup_req_alloc & fl_empty;
            resp_q.flowid   <= hit      ? FLOWID_MAX_W'(hit_id)    :
                               alloc_do ? FLOWID_MAX_W'(fl_pop_id) : '0;
        end else if (lookup_resp_rdy) begin
            lookup_resp_val <= 1'b0;
        end
    end

    assign lookup_resp_hit    = resp_q.hit;
    assign lookup_resp_new    = resp_q.new_flow;
    assign lookup_resp_full   = resp_q.full;
    assign lookup_resp_flowid = resp_q.flowid[FLOWID_W-1:0];

    generate
        if (FLOWID_W < FLOWID_MAX_W) begin : g_flowid_hi
            logic unused_flowid_hi;
            assign unused_flowid_hi = ^resp_q.flowid[FLOWID_MAX_W-1:FLOWID_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            active_flows <= '0;
            free_err     <= 1'b0;
        end else begin
            active_flows <= active_flows + (FLOWID_W+1)'(alloc_do) - (FLOWID_W+1)'(free_ok);
            free_err     <= free_acc & ~free_vld;
        end
    end

    a_id_conservation: assert property (@(posedge clk) disable iff (rst)
        ready |-> ((FLOWID_W+2)'(fl_count) + (FLOWID_W+2)'(active_flows) == (FLOWID_W+2)'(NUM_FLOWS)));

endmodule

// File: tb/tb_tcp_flow_table.sv
// Randomized scoreboard bench for tcp_flow_table against an associative-array flow model.
module tb_tcp_flow_table;
    import tcp_pkg::*;

    localparam int N  = 64;
    localparam int IW = 6;
    localparam int TW = 96;
    localparam int NPOOL = 80;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          init_done;
    logic          lookup_req_val = 1'b0;
    logic [TW-1:0] lookup_req_tag = '0;
    logic          lookup_req_alloc = 1'b0;
    logic          lookup_req_rdy;
    logic          lookup_resp_val;
    logic          lookup_resp_hit;
    logic          lookup_resp_new;
    logic          lookup_resp_full;
    logic [IW-1:0] lookup_resp_flowid;
    logic          lookup_resp_rdy = 1'b0;
    logic          free_req_val = 1'b0;
    logic [IW-1:0] free_req_flowid = '0;
    logic          free_req_rdy;
    logic          free_err;
    logic [IW:0]   active_flows;

    tcp_flow_table #(.NUM_FLOWS(N), .TAG_W(TW)) dut (
        .clk                (clk),
        .rst                (rst),
        .init_done          (init_done),
        .lookup_req_val     (lookup_req_val),
        .lookup_req_tag     (lookup_req_tag),
        .lookup_req_alloc   (lookup_req_alloc),
        .lookup_req_rdy     (lookup_req_rdy),
        .lookup_resp_val    (lookup_resp_val),
        .lookup_resp_hit    (lookup_resp_hit),
        .lookup_resp_new    (lookup_resp_new),
        .lookup_resp_full   (lookup_resp_full),
        .lookup_resp_flowid (lookup_resp_flowid),
        .lookup_resp_rdy    (lookup_resp_rdy),
        .free_req_val       (free_req_val),
        .free_req_flowid    (free_req_flowid),
        .free_req_rdy       (free_req_rdy),
        .free_err           (free_err),
        .active_flows       (active_flows)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit hit;
        bit nw;
        bit full;
        int id;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;

    // Reference model: which tuple owns which ID, plus the FIFO of unused IDs.
    int            tag2id [logic [TW-1:0]];
    logic [TW-1:0] id_tag [N];
    bit            vld_m  [N];
    int            fl_m[$];
    int            act_m = 0;
    bit            ready_m = 0;
    bit            pend_m = 0;
    bit            err_pend = 0;
    logic [TW-1:0] pool [NPOOL];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [TW-1:0] mk_tag(input int i);
        flow_lookup_entry e;
        e.src_ip   = 32'hC0A8_0000 | 32'(i);
        e.dst_ip   = 32'h0A00_0001;
        e.src_port = 16'(i);
        e.dst_port = 16'd80;
        return e;
    endfunction

    // Monitor: compare every presented response to the oldest expectation; pop on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && lookup_resp_val) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexpected actual=valid required=none at %0t", $time);
                end else begin
                    chk("resp_hit",    lookup_resp_hit,    exp_q[0].hit);
                    chk("resp_new",    lookup_resp_new,    exp_q[0].nw);
                    chk("resp_full",   lookup_resp_full,   exp_q[0].full);
                    chk("resp_flowid", lookup_resp_flowid, exp_q[0].id);
                    if (lookup_resp_rdy) void'(exp_q.pop_front());
                end
            end
        end
    end

    // One clock of stimulus, entered and left at posedge+1.
    task automatic step(input bit lv, input logic [TW-1:0] tag, input bit al,
                        input bit fv, input int fid, input bit rr);
        bit   acc;
        bit   exp_rdy;
        bit   fvld;
        exp_t e;
        lookup_req_val   = lv;
        lookup_req_tag   = tag;
        lookup_req_alloc = al;
        free_req_val     = fv;
        free_req_flowid  = IW'(fid);
        lookup_resp_rdy  = rr;
        @(negedge clk);
        exp_rdy = ready_m && (!pend_m || rr);
        chk("req_rdy",      lookup_req_rdy,  exp_rdy);
        chk("free_rdy",     free_req_rdy,    ready_m);
        chk("resp_val",     lookup_resp_val, pend_m);
        chk("active_flows", active_flows,    act_m);
        chk("free_err",     free_err,        err_pend);
        fvld = vld_m[fid];
        acc  = lv && exp_rdy;
        if (acc) begin
            e.hit = 0; e.nw = 0; e.full = 0; e.id = 0;
            if (tag2id.exists(tag)) begin
                e.hit = 1;
                e.id  = tag2id[tag];
            end else if (al) begin
                if (fl_m.size() > 0) begin
                    e.nw = 1;
                    e.id = fl_m.pop_front();
                    tag2id[tag]  = e.id;
                    id_tag[e.id] = tag;
                    vld_m[e.id]  = 1;
                    act_m++;
                end else begin
                    e.full = 1;
                end
            end
            exp_q.push_back(e);
        end
        err_pend = 0;
        if (fv && ready_m) begin
            if (fvld) begin
                vld_m[fid] = 0;
                tag2id.delete(id_tag[fid]);
                fl_m.push_back(fid);
                act_m--;
            end else begin
                err_pend = 1;
            end
        end
        pend_m = acc ? 1'b1 : (rr ? 1'b0 : pend_m);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        lookup_req_val  = 1'b0;
        free_req_val    = 1'b0;
        lookup_resp_rdy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_init_done",    init_done,       0);
        chk("rst_req_rdy",      lookup_req_rdy,  0);
        chk("rst_free_rdy",     free_req_rdy,    0);
        chk("rst_resp_val",     lookup_resp_val, 0);
        chk("rst_active_flows", active_flows,    0);
        chk("rst_free_err",     free_err,        0);
        exp_q.delete();
        tag2id.delete();
        fl_m.delete();
        for (int i = 0; i < N; i++) vld_m[i] = 0;
        act_m = 0; ready_m = 0; pend_m = 0; err_pend = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 1; k <= N; k++) begin
            @(posedge clk);
            #1;
            if (k == N-1) begin
                chk("init_done_early", init_done,      0);
                chk("init_req_rdy",    lookup_req_rdy, 0);
            end
            if (k == N) chk("init_done_on_time", init_done, 1);
        end
        chk("init_active_flows", active_flows, 0);
        ready_m = 1;
        for (int i = 0; i < N; i++) fl_m.push_back(i);
    endtask

    initial begin
        logic [TW-1:0] old5;
        for (int i = 0; i < NPOOL; i++) pool[i] = {$urandom(), $urandom(), $urandom()};

        do_reset();

        step(1, mk_tag(1), 1, 0, 0, 1);
        step(1, mk_tag(1), 1, 0, 0, 1);
        step(1, mk_tag(2), 1, 0, 0, 1);
        step(0, '0, 0, 0, 0, 1);
        chk("two_flows", active_flows, 2);

        for (int i = 2; i < N; i++) step(1, mk_tag(100 + i), 1, 0, 0, 1);
        step(1, mk_tag(999), 1, 0, 0, 1);
        step(0, '0, 0, 0, 0, 1);
        chk("table_full", active_flows, N);

        old5 = id_tag[5];
        step(0, '0, 0, 1, 5, 1);
        step(1, old5, 0, 0, 0, 1);
        step(1, mk_tag(1000), 1, 0, 0, 1);

        step(0, '0, 0, 1, 7, 1);
        step(0, '0, 0, 1, 7, 1);
        step(1, mk_tag(1001), 1, 0, 0, 1);

        step(1, mk_tag(1002), 1, 1, 3, 1);
        step(1, mk_tag(1002), 1, 0, 0, 1);

        // Back-pressure: one accepted request, then five stalled cycles.
        step(1, mk_tag(1), 0, 0, 0, 0);
        repeat (5) step(1, mk_tag(2), 0, 0, 0, 0);
        step(0, '0, 0, 0, 0, 1);
        step(0, '0, 0, 0, 0, 1);

        for (int i = 0; i < N; i++) step(0, '0, 0, 1, i, 1);

        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 3) != 0, pool[$urandom_range(0, NPOOL-1)],
                 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                 int'($urandom_range(0, N-1)), $urandom_range(0, 3) != 0);
        end

        // Mid-stream reset with a response held pending.
        step(1, pool[0], 1, 0, 0, 0);
        do_reset();
        for (int i = 0; i < NPOOL; i++) step(1, pool[i], 0, 0, 0, 1);
        step(1, mk_tag(1), 0, 0, 0, 1);
        step(0, '0, 0, 0, 0, 1);
        step(0, '0, 0, 0, 0, 1);
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
